// File: rtl/slice_add_seq.sv
// Purpose : W-bit adder built by time-multiplexing one external COUNT-bit select_adder.
// Latency : start accepted at edge 0 -> done pulse between edges SLICES and SLICES+1.
// Backpres: no flow control; start is only sampled in IDLE and ignored while busy.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, A, B, Cin       request and operands, captured when start is accepted
//   sl_A, sl_B, sl_Cin     current slice operands/carry driven to the select_adder
//   sl_S, sl_Cout          select_adder result for the current slice
//   busy, done             busy in RUN and DONE; done is a one-cycle result strobe
//   S, Cout                registered sum and final carry-out
//   ovf                    two's-complement overflow, only when SLICE_ADD_OVF_EN is defined
module slice_add_seq #(
  parameter int COUNT  = 4,
  parameter int SLICES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [COUNT*SLICES-1:0]   A,
  input  logic [COUNT*SLICES-1:0]   B,
  input  logic                      Cin,
  output logic [COUNT-1:0]          sl_A,
  output logic [COUNT-1:0]          sl_B,
  output logic                      sl_Cin,
  input  logic [COUNT-1:0]          sl_S,
  input  logic                      sl_Cout,
  output logic                      busy,
  output logic                      done,
  output logic [COUNT*SLICES-1:0]   S,
  output logic                      Cout
`ifdef SLICE_ADD_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int W     = COUNT * SLICES;
  // Keep the index at least one bit wide so SLICES=1 still elaborates.
  localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_s;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;
`ifdef SLICE_ADD_OVF_EN
  logic               r_ovf;
`endif

  logic               w_run;
  logic               w_last;

  assign w_run  = (r_state == RUN);
  assign w_last = (r_idx == IDX_W'(SLICES - 1));

  // Slice operands are only presented while an addition is in flight.
  assign sl_A   = w_run ? r_a[int'(r_idx)*COUNT +: COUNT] : '0;
  assign sl_B   = w_run ? r_b[int'(r_idx)*COUNT +: COUNT] : '0;
  assign sl_Cin = w_run ? r_carry : 1'b0;

  assign S    = r_s;
  assign Cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;
`ifdef SLICE_ADD_OVF_EN
  assign ovf  = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SLICE_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_s[int'(r_idx)*COUNT +: COUNT] <= sl_S;
          r_carry <= sl_Cout;
          if (w_last) begin
            r_cout  <= sl_Cout;
            r_idx   <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
`ifdef SLICE_ADD_OVF_EN
            // The final sum MSB is the top bit of the slice being written now.
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (sl_S[COUNT-1] != r_a[W-1]);
`endif
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_add_seq.sv
// Purpose : self-checking bench for slice_add_seq with a behavioural select_adder attached.
// Latency : checks done arrives SLICES edges after start acceptance.
// Backpres: none; start pulses mid-operation must be ignored.
module tb_slice_add_seq;

  localparam int COUNT  = 4;
  localparam int SLICES = 4;
  localparam int W      = COUNT * SLICES;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     A     = '0;
  logic [W-1:0]     B     = '0;
  logic             Cin   = 1'b0;
  logic [COUNT-1:0] sl_A;
  logic [COUNT-1:0] sl_B;
  logic             sl_Cin;
  logic [COUNT-1:0] sl_S;
  logic             sl_Cout;
  logic             busy;
  logic             done;
  logic [W-1:0]     S;
  logic             Cout;
`ifdef SLICE_ADD_OVF_EN
  logic             ovf;
`endif

  // External select_adder: plain COUNT-bit ripple sum.
  logic [COUNT:0]   w_sa;
  assign w_sa    = {1'b0, sl_A} + {1'b0, sl_B} + {{COUNT{1'b0}}, sl_Cin};
  assign sl_S    = w_sa[COUNT-1:0];
  assign sl_Cout = w_sa[COUNT];

  slice_add_seq #(.COUNT(COUNT), .SLICES(SLICES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
    .sl_A    (sl_A),
    .sl_B    (sl_B),
    .sl_Cin  (sl_Cin),
    .sl_S    (sl_S),
    .sl_Cout (sl_Cout),
    .busy    (busy),
    .done    (done),
    .S       (S),
    .Cout    (Cout)
`ifdef SLICE_ADD_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  int           n_vec  = 0;
  int           n_bad  = 0;
  int           n_done = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("S", 32'(S), 32'(mon_e[W-1:0]));
        chk("Cout", 32'(Cout), 32'(mon_e[W]));
      end
    end
  end

  // Drive one request and follow it until done (bounded).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit mid, output int lat, output int bsy,
                        output logic [SLICES-1:0] trace);
    logic [W:0] sum;
    bit         seen;
    seen  = 1'b0;
    lat   = -1;
    bsy   = 0;
    trace = '0;
    @(posedge clk); #1;
    A = a; B = b; Cin = cin; start = 1'b1;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_q.push_back(sum);
    @(posedge clk); #1;
    // Scramble the inputs so only captured operands can produce the right answer.
    start = 1'b0; A = 16'($urandom); B = 16'($urandom); Cin = 1'b1;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (busy === 1'b1) bsy++;
      if (n <= SLICES) trace[n-1] = sl_Cin;
      if (mid && n == 2) begin start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; end
      if (mid && n == 3) start = 1'b0;
      if (done === 1'b1) begin lat = n - 1; seen = 1'b1; end
    end
  endtask

  task automatic op_checked(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input bit mid, output logic [SLICES-1:0] trace);
    int         lat;
    int         bsy;
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    run_op(a, b, cin, mid, lat, bsy, trace);
    chk("latency", 32'(lat), 32'(SLICES));
    chk("busy_cycles", 32'(bsy), 32'(SLICES + 1));
`ifdef SLICE_ADD_OVF_EN
    chk("ovf", 32'(ovf), 32'((a[W-1] == b[W-1]) && (sum[W-1] != a[W-1])));
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("sl_idle", {sl_Cin, sl_A, sl_B}, 32'd0);
    chk("S_hold", 32'(S), 32'(sum[W-1:0]));
    chk("Cout_hold", 32'(Cout), 32'(sum[W]));
  endtask

  initial begin
    logic [SLICES-1:0] trace;
    int                d0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_Cout", 32'(Cout), 32'd0);
    chk("rst_sl", {sl_Cin, sl_A, sl_B}, 32'd0);
    rst_n = 1'b1;

    op_checked(16'h0000, 16'h0001, 1'b0, 1'b0, trace);
    op_checked(16'hFFFF, 16'h0001, 1'b0, 1'b0, trace);
    chk("carry_chain", 32'(trace), 32'b1110);
    op_checked(16'h1234, 16'h4321, 1'b1, 1'b1, trace);
    op_checked(16'h7FFF, 16'h0001, 1'b0, 1'b0, trace);
    op_checked(16'h8000, 16'h8000, 1'b1, 1'b0, trace);
    op_checked(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, trace);
    chk("carry_chain_all", 32'(trace), 32'b1111);

    // Asynchronous reset while idx == 2.
    @(posedge clk); #1;
    A = 16'h00F0; B = 16'h0F0F; Cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 16'h0FFF});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_S_low", 32'(S[7:0]), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_S", 32'(S), 32'd0);
    chk("arst_Cout", 32'(Cout), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    exp_q.delete();
    d0 = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", 32'(n_done - d0), 32'd0);
    op_checked(16'h1111, 16'h2222, 1'b0, 1'b0, trace);

    for (int i = 0; i < 8; i++) begin
      op_checked(16'($urandom), 16'($urandom), 1'($urandom), (i % 3) == 0, trace);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slice_add_seq.md
SLICE_ADD_SEQ -- requirements
Module: slice_add_seq

Interface
REQ-001 Parameter COUNT, default 4, SHALL set the slice width, equal to the external select_adder width.
REQ-002 Parameter SLICES, default 4, SHALL set the number of slices; legal range 1..16. W = COUNT*SLICES.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL request one W-bit addition; sampled only in IDLE.
REQ-006 A  in  W  SHALL be operand A, captured when start is accepted.
REQ-007 B  in  W  SHALL be operand B, captured when start is accepted.
REQ-008 Cin  in  1  SHALL be the carry-in, captured when start is accepted.
REQ-009 sl_A  out  COUNT  SHALL be the current A slice driven to the select_adder.
REQ-010 sl_B  out  COUNT  SHALL be the current B slice driven to the select_adder.
REQ-011 sl_Cin  out  1  SHALL be the chained carry driven to the select_adder.
REQ-012 sl_S  in  COUNT  SHALL be the select_adder sum for the current slice.
REQ-013 sl_Cout  in  1  SHALL be the select_adder carry-out for the current slice.
REQ-014 busy  out  1  SHALL be high in RUN and DONE.
REQ-015 done  out  1  SHALL be a one-cycle pulse marking S and Cout valid.
REQ-016 S  out  W  SHALL be the registered W-bit sum.
REQ-017 Cout  out  1  SHALL be the registered final carry-out.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-019 IDLE: start=1 at an edge SHALL capture A, B and Cin, set slice index idx=0 and carry register=Cin, and go to RUN.
REQ-020 RUN: sl_A/sl_B SHALL be the captured bits [idx*COUNT +: COUNT], and sl_Cin SHALL be the carry register.
REQ-021 RUN, each edge: S[idx*COUNT +: COUNT] <= sl_S, carry <= sl_Cout, idx <= idx+1.
REQ-022 RUN with idx==SLICES-1: the edge SHALL write the last slice, load Cout from sl_Cout and go to DONE.
REQ-023 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-024 Latency: start accepted at edge 0 SHALL give done high between edges SLICES and SLICES+1; SLICES=1 gives a single RUN cycle.
REQ-025 Outside RUN, sl_A, sl_B and sl_Cin SHALL be driven to 0.
REQ-026 start in RUN or DONE SHALL be ignored, with no effect on captured operands or results.
REQ-027 S and Cout SHALL hold their values from DONE until the next accepted start. S bits may change slice-wise during RUN; they are valid only from done onward.
REQ-028 The sum SHALL be modulo 2^W, with the carry-out reported only via Cout; there SHALL be no saturation.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, idx=0, carry=0, S=0, Cout=0, done=0, busy=0, and clear the captured operands.
REQ-030 Reset during RUN or DONE SHALL abort the operation, with no done pulse afterwards; the first start after rst_n rises SHALL behave as from power-up.

Configuration
REQ-031 Macro SLICE_ADD_OVF_EN defined: add output port ovf (out, 1), reset 0, loaded with Cout in DONE entry as two's-complement overflow = (A[W-1]==B[W-1]) && (S[W-1]!=A[W-1]) using captured operands and final sum.
REQ-032 Macro SLICE_ADD_OVF_EN undefined: no ovf port and no associated logic; all other behaviour SHALL be identical.

Verification (COUNT=4, SLICES=4, W=16, external select_adder connected)
REQ-033 A=0x0000, B=0x0001, Cin=0, start -> done exactly 4 edges after acceptance, S=0x0001, Cout=0, busy high for 5 cycles.
REQ-034 A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1; carry propagates through all 4 slices (sl_Cin=1 in slices 1..3).
REQ-035 A=0x1234, B=0x4321, Cin=1 -> S=0x5556, Cout=0; a second start pulsed mid-RUN is ignored and the result is unchanged.
REQ-036 rst_n low while idx=2 -> busy=0, S=0x0000, Cout=0 asynchronously; no done pulse follows; a new start then completes normally.
REQ-037 With SLICE_ADD_OVF_EN: A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, ovf=1; A=0xFFFF, B=0x0001 -> ovf=0.
